mvm_uart_ctrl: RTL and testbench
================================

MVM_UART_CTRL -- requirements
Module: mvm_uart_ctrl

Interface
REQ-001 SHALL have parameter R, default 2: matrix rows.
REQ-002 SHALL have parameter C, default 2: matrix columns and vector length.
REQ-003 SHALL have parameter W_X, default 4: x element width.
REQ-004 SHALL have parameter W_K, default 2: k element width.
REQ-005 SHALL have parameter W_Y_OUT, default 8: transmitted y element width.
REQ-006 SHALL have parameter BITS_PER_WORD, default 8: UART word width.
REQ-007 SHALL have derived localparams:
- W_BUS_KX = R*C*W_K + C*W_X
- W_BUS_Y = R*W_Y_OUT
- N_WORDS_KX = W_BUS_KX/BITS_PER_WORD
- N_WORDS_Y = W_BUS_Y/BITS_PER_WORD
REQ-008 SHALL fail elaboration unless W_BUS_KX and W_BUS_Y are exact multiples of BITS_PER_WORD.
REQ-009 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-010 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-011 SHALL have ports s_valid (input, 1), s_ready (output, 1) and s_data (input, BITS_PER_WORD): received byte stream from UART RX.
REQ-012 SHALL have ports kx_data (output, W_BUS_KX), kx_valid (output, 1) and kx_ready (input, 1): operand request to the MVM datapath; kx_data = {k, x}, with x in the LSBs.
REQ-013 SHALL have ports y_data (input, W_BUS_Y), y_valid (input, 1) and y_ready (output, 1): result from the MVM datapath.
REQ-014 SHALL have ports m_data (output, BITS_PER_WORD), m_valid (output, 1) and m_ready (input, 1): byte stream to UART TX.
REQ-015 SHALL have port busy, output, 1: high whenever state is not RX or the RX byte counter is nonzero.

Function
REQ-016 SHALL implement a four-state FSM: RX, REQ, WAIT_Y, TX.
REQ-017 SHALL complete a handshake on any channel in a cycle where valid && ready at a rising edge.
REQ-018 SHALL behave as follows in RX:
- s_ready = 1.
- Each accepted byte is written to kx word index cnt, occupying bits [cnt*BITS_PER_WORD +: BITS_PER_WORD].
- cnt then increments.
- The byte accepted with cnt == N_WORDS_KX-1 clears cnt and moves the FSM to REQ on the next cycle.
REQ-019 SHALL behave as follows in REQ: kx_valid = 1; on a kx handshake, go to WAIT_Y.
REQ-020 SHALL hold kx_data stable from entry to REQ until the FSM returns to RX, and hold it in all other states.
REQ-021 SHALL behave as follows in WAIT_Y:
- y_ready = 1.
- On a y handshake, register y_data into the TX buffer, clear cnt and go to TX.
REQ-022 SHALL behave as follows in TX:
- m_valid = 1.
- m_data = TX buffer word cnt, word 0 = bits [BITS_PER_WORD-1:0], LSB word first.
- On an m handshake, cnt increments.
- The handshake at cnt == N_WORDS_Y-1 clears cnt and returns the FSM to RX.
REQ-023 SHALL deassert each ready/valid output in every state other than the one named above for it; s_valid outside RX is ignored and the byte dropped.
REQ-024 SHALL keep m_data constant while m_valid && !m_ready (backpressure); kx_valid likewise holds until kx_ready.
REQ-025 SHALL drive all outputs from registers or pure state decode, with no combinational path from any input to any output.
REQ-026 SHALL have the following latencies:
- Last RX byte to kx_valid: 1 cycle.
- y handshake to first m_valid: 1 cycle.
- Last m handshake to s_ready: 1 cycle.
REQ-027 SHALL support back-to-back frames with no extra idle cycles beyond REQ-026.
REQ-028 SHALL wrap cnt only as stated; cnt never exceeds max(N_WORDS_KX, N_WORDS_Y)-1.

Reset
REQ-029 SHALL, on a clk edge with rst = 1 in any state, go to RX with:
- cnt = 0
- kx register = 0
- TX buffer = 0
- s_ready = 1 on the first cycle after rst deasserts
- kx_valid = y_ready = m_valid = busy = 0
- kx_data = 0, m_data = 0
REQ-030 SHALL have reset take priority over every simultaneous handshake.
REQ-031 SHALL discard any partially received or partially transmitted frame on reset mid-operation.

Verification
REQ-032 Defaults, s_data 0x5A then 0xC3 -> kx_data = 0xC35A, kx_valid rises 1 cycle after the second byte.
REQ-033 Result y_data = 0x12FE, m_ready = 1 -> m_data 0xFE, then 0x12, then s_ready = 1 next cycle.
REQ-034 m_ready held low 5 cycles during word 0 -> m_valid = 1 and m_data = 0xFE stable throughout; word 1 follows after release.
REQ-035 s_valid pulsed with 0xFF during WAIT_Y and TX -> ignored; the next frame's kx_data is unaffected.
REQ-036 rst after one RX byte, and separately during TX word 1 -> all outputs at reset values, busy = 0; a fresh 2-byte frame then completes correctly.
REQ-037 Two frames back-to-back with kx_ready and y_valid delayed by random 0-20 cycles -> both result byte pairs emitted in order, matching the software MVM reference model.

Source files
------------

// File: rtl/mvm_uart_ctrl.sv
// UART-side framing controller for a matrix-vector multiplier: collects a {k, x}
// operand frame byte by byte, hands it to the datapath, and streams the result back.
module mvm_uart_ctrl #(
  parameter int R             = 2,
  parameter int C             = 2,
  parameter int W_X           = 4,
  parameter int W_K           = 2,
  parameter int W_Y_OUT       = 8,
  parameter int BITS_PER_WORD = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [BITS_PER_WORD-1:0]              s_data,
  output logic [R*C*W_K+C*W_X-1:0]              kx_data,
  output logic                                  kx_valid,
  input  logic                                  kx_ready,
  input  logic [R*W_Y_OUT-1:0]                  y_data,
  input  logic                                  y_valid,
  output logic                                  y_ready,
  output logic [BITS_PER_WORD-1:0]              m_data,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic                                  busy,
  output logic [1:0]                            state_dbg
);

  localparam int W_BUS_KX   = R*C*W_K + C*W_X;
  localparam int W_BUS_Y    = R*W_Y_OUT;
  localparam int N_WORDS_KX = W_BUS_KX / BITS_PER_WORD;
  localparam int N_WORDS_Y  = W_BUS_Y / BITS_PER_WORD;
  localparam int N_MAX      = (N_WORDS_KX > N_WORDS_Y) ? N_WORDS_KX : N_WORDS_Y;
  localparam int CW         = (N_MAX > 1) ? $clog2(N_MAX) : 1;

  if ((W_BUS_KX % BITS_PER_WORD) != 0 || (W_BUS_Y % BITS_PER_WORD) != 0) begin : g_bad_width
    $error("mvm_uart_ctrl: bus widths must be whole multiples of BITS_PER_WORD");
  end

  // Every channel uses valid/ready: a transfer happens on a rising edge where both
  // are high; a valid source holds its data unchanged until that edge.
  typedef enum logic [1:0] {RX = 2'd0, REQ = 2'd1, WAIT_Y = 2'd2, TX = 2'd3} state_t;

  state_t                state, state_next;
  logic [CW-1:0]         cnt, cnt_next;
  logic [W_BUS_KX-1:0]   kx_reg, kx_next;
  logic [W_BUS_Y-1:0]    tx_buf, tx_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RX;
      cnt    <= '0;
      kx_reg <= '0;
      tx_buf <= '0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      kx_reg <= kx_next;
      tx_buf <= tx_next;
    end
  end

  // Ready/valid outputs decode the state only, so no input reaches an output.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    kx_next    = kx_reg;
    tx_next    = tx_buf;
    s_ready    = 1'b0;
    kx_valid   = 1'b0;
    y_ready    = 1'b0;
    m_valid    = 1'b0;
    unique case (state)
      RX: begin
        s_ready = 1'b1;
        if (s_valid) begin
          for (int i = 0; i < N_WORDS_KX; i++) begin
            if (cnt == CW'(i)) kx_next[i*BITS_PER_WORD +: BITS_PER_WORD] = s_data;
          end
          if (cnt == CW'(N_WORDS_KX-1)) begin
            cnt_next   = '0;
            state_next = REQ;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
      end
      REQ: begin
        kx_valid = 1'b1;
        if (kx_ready) state_next = WAIT_Y;
      end
      WAIT_Y: begin
        y_ready = 1'b1;
        if (y_valid) begin
          tx_next    = y_data;
          cnt_next   = '0;
          state_next = TX;
        end
      end
      TX: begin
        m_valid = 1'b1;
        if (m_ready) begin
          if (cnt == CW'(N_WORDS_Y-1)) begin
            cnt_next   = '0;
            state_next = RX;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
      end
      default: state_next = RX;
    endcase
  end

  always_comb begin
    m_data = '0;
    for (int i = 0; i < N_WORDS_Y; i++) begin
      if (cnt == CW'(i)) m_data = tx_buf[i*BITS_PER_WORD +: BITS_PER_WORD];
    end
  end

  assign kx_data   = kx_reg;
  assign busy      = (state != RX) || (cnt != '0);
  assign state_dbg = state;

endmodule

// File: tb/tb_mvm_uart_ctrl.sv
// Bench for mvm_uart_ctrl: the bench plays UART RX/TX and the MVM datapath, and a
// per-cycle compare process checks outputs against a frame-level software model.
module tb_mvm_uart_ctrl;

  localparam int R = 2, C = 2, W_X = 4, W_K = 2, W_Y_OUT = 8, BPW = 8;
  localparam int W_BUS_KX = R*C*W_K + C*W_X;
  localparam int W_BUS_Y  = R*W_Y_OUT;
  localparam int N_KX     = W_BUS_KX / BPW;
  localparam int N_Y      = W_BUS_Y / BPW;
  localparam int TO       = 200;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                s_valid = 1'b0, s_ready;
  logic [BPW-1:0]      s_data = '0;
  logic [W_BUS_KX-1:0] kx_data;
  logic                kx_valid, kx_ready = 1'b0;
  logic [W_BUS_Y-1:0]  y_data = '0;
  logic                y_valid = 1'b0, y_ready;
  logic [BPW-1:0]      m_data;
  logic                m_valid, m_ready = 1'b0;
  logic                busy;
  logic [1:0]          state_dbg;

  mvm_uart_ctrl #(.R(R), .C(C), .W_X(W_X), .W_K(W_K), .W_Y_OUT(W_Y_OUT), .BITS_PER_WORD(BPW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .kx_data(kx_data), .kx_valid(kx_valid), .kx_ready(kx_ready),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .state_dbg(state_dbg)
  );

  // scoreboard state
  int                  checks = 0;
  int                  errors = 0;
  logic [BPW-1:0]      exp_q[$];
  logic [W_BUS_KX-1:0] exp_kx = '0;
  bit                  idle = 1'b1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out after %0d cycles, required a handshake", name, TO);
  endtask

  // software MVM: y_i = sum_j k[i][j] * x[j], unsigned, kept to W_Y_OUT bits
  function automatic logic [W_BUS_Y-1:0] mvm(logic [W_BUS_KX-1:0] kx);
    logic [W_BUS_Y-1:0]  y;
    logic [W_BUS_KX-1:0] t;
    int                  acc, xv, kv;
    y = '0;
    for (int i = 0; i < R; i++) begin
      acc = 0;
      for (int j = 0; j < C; j++) begin
        t   = kx >> (j*W_X);
        xv  = int'(t[W_X-1:0]);
        t   = kx >> (C*W_X + (i*C + j)*W_K);
        kv  = int'(t[W_K-1:0]);
        acc = acc + kv*xv;
      end
      y[i*W_Y_OUT +: W_Y_OUT] = W_Y_OUT'(acc);
    end
    return y;
  endfunction

  // driver tasks: all start and end one time unit after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; kx_ready = 1'b0; y_valid = 1'b0; m_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    exp_q.delete();
    exp_kx = '0;
    idle = 1'b1;
  endtask

  task automatic check_reset_vals();
    check("rst_s_ready", s_ready, 1);
    check("rst_kx_valid", kx_valid, 0);
    check("rst_y_ready", y_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_kx_data", kx_data, 0);
    check("rst_m_data", m_data, 0);
  endtask

  task automatic send_byte(logic [BPW-1:0] b);
    int n = 0;
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && n < TO) begin tick(); n++; end
    if (!s_ready) begin timeout("s_ready"); s_valid = 1'b0; return; end
    tick();
    s_valid = 1'b0;
    s_data  = BPW'($urandom);
    idle    = 1'b0;
  endtask

  task automatic send_frame(logic [W_BUS_KX-1:0] f);
    exp_kx = f;
    for (int w = 0; w < N_KX; w++) send_byte(f[w*BPW +: BPW]);
  endtask

  // datapath stand-in: accept kx after dk cycles, return y after dy more
  task automatic serve(int dk, int dy, bit use_ovr, logic [W_BUS_Y-1:0] ovr, bit junk);
    logic [W_BUS_Y-1:0] y;
    int n = 0;
    while (!kx_valid && n < TO) begin tick(); n++; end
    if (!kx_valid) begin timeout("kx_valid"); return; end
    repeat (dk) tick();
    kx_ready = 1'b1;
    tick();
    kx_ready = 1'b0;
    if (junk) begin s_valid = 1'b1; s_data = 8'hFF; end
    y = use_ovr ? ovr : mvm(exp_kx);
    for (int w = 0; w < N_Y; w++) exp_q.push_back(y[w*BPW +: BPW]);
    repeat (dy) tick();
    y_valid = 1'b1;
    y_data  = y;
    n = 0;
    while (!y_ready && n < TO) begin tick(); n++; end
    if (!y_ready) begin timeout("y_ready"); y_valid = 1'b0; return; end
    tick();
    y_valid = 1'b0;
    y_data  = W_BUS_Y'($urandom);
  endtask

  task automatic drain_rand();
    bit done;
    int n;
    for (int w = 0; w < N_Y; w++) begin
      done = 1'b0;
      n    = 0;
      while (!done && n < TO) begin
        m_ready = 1'($urandom_range(0, 1));
        if (m_valid && m_ready) done = 1'b1;
        tick();
        n++;
      end
      if (!done) timeout("m_handshake");
    end
    m_ready = 1'b0;
    s_valid = 1'b0;
    idle    = 1'b1;
  endtask

  task automatic random_frame(int max_delay);
    send_frame(W_BUS_KX'($urandom));
    serve($urandom_range(0, max_delay), $urandom_range(0, max_delay), 1'b0, '0, 1'b0);
    drain_rand();
  endtask

  // compare process: every cycle outside reset
  always @(negedge clk) begin
    if (!rst) begin
      check("one_hot_handshake", 64'($countones({s_ready, kx_valid, y_ready, m_valid})), 1);
      check("busy", busy, !idle);
      if (!s_ready) check("kx_data_hold", kx_data, exp_kx);
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL m_data_unexpected: got %0h, required no m_valid", m_data);
        end else begin
          check("m_data", m_data, exp_q[0]);
          if (m_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check_reset_vals();

    // literal pins on the software model
    check("mvm_pin_c35a", mvm(16'hC35A), 16'h0F1E);
    check("mvm_pin_ffff", mvm(16'hFFFF), 16'h5A5A);

    // frame A: 0x5A, 0xC3; result 0x12FE with m_ready high
    send_frame(16'hC35A);
    check("kx_valid_latency", kx_valid, 1);
    check("kx_data_c35a", kx_data, 16'hC35A);
    serve(0, 0, 1'b1, 16'h12FE, 1'b0);
    check("m_valid_latency", m_valid, 1);
    check("m_word0_fe", m_data, 8'hFE);
    m_ready = 1'b1;
    tick();
    check("m_word1_12", m_data, 8'h12);
    tick();
    m_ready = 1'b0;
    idle    = 1'b1;
    check("s_ready_after_tx", s_ready, 1);

    // frame B: backpressure on word 0, junk 0xFF bytes during WAIT_Y and TX
    send_frame(W_BUS_KX'($urandom));
    serve(3, 4, 1'b1, 16'h12FE, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("stall_m_valid", m_valid, 1);
      check("stall_m_data", m_data, 8'hFE);
      tick();
    end
    m_ready = 1'b1;
    tick();
    check("post_stall_word1", m_data, 8'h12);
    tick();
    m_ready = 1'b0;
    s_valid = 1'b0;
    idle    = 1'b1;

    // frame C: kx must hold only the bytes sent for this frame
    random_frame(5);

    // reset after one RX byte
    send_byte(8'hA5);
    check("busy_mid_rx", busy, 1);
    do_reset();
    check_reset_vals();
    random_frame(5);

    // reset while TX word 1 is pending
    send_frame(W_BUS_KX'($urandom));
    serve($urandom_range(0, 5), $urandom_range(0, 5), 1'b0, '0, 1'b0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    tick();
    do_reset();
    check_reset_vals();
    random_frame(5);

    // back-to-back frames with random datapath delays
    for (int f = 0; f < 8; f++) random_frame(20);

    check("exp_q_drained", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
